ctrl_interrupciones: RTL and testbench
======================================

# ctrl_interrupciones

Interrupt controller that sits directly upstream of the CPU and drives its `interrupcion` input and 2-bit interrupt-source selection. It synchronises and edge-detects four asynchronous event lines and latches them as pending requests. It masks and prioritises those requests and holds a request/acknowledge handshake with the control unit. An optional periodic timer can replace event line 3 as an interrupt source.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops per event line (legal ≥2).
- PRESCALE, 16: clk cycles per timer tick (legal ≥2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ev  in  4  raw event lines, asynchronous to clk; a rising edge raises a request.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_addr  in  1  0 = mask register, 1 = timer period register.
- cfg_data  in  8  write data; the mask uses bits [3:0].
- ack  in  1  one-cycle acknowledge from the control unit when it takes the interrupt.
- interrupcion  out  1  registered interrupt request to the CPU.
- vector  out  2  index of the source being requested; stable while interrupcion=1.
- pending  out  4  pending register, readable by software through a CPU input port.

## Operation
- Per line: SYNC_STAGES-flop synchroniser, then one edge-detect flop.
  - A synchronised 0→1 sets pending[i].
  - pending[i] is set regardless of the mask.
- Request condition: `|(pending & mask)`.
- Priority: the lowest index wins; source 0 is the highest priority.
- FSM states:
  - IDLE: if the request condition holds, latch vector = highest-priority masked pending index, assert interrupcion, go to REQ.
  - REQ: hold interrupcion and vector. On ack: clear pending[vector], deassert interrupcion, go to GAP.
  - GAP: one cycle with interrupcion=0, then go to IDLE unconditionally.
- ack in IDLE or GAP is ignored and has no effect on pending.
- New edge on pending[vector] in the same cycle as ack: the set wins, so the bit stays 1.
- Mask write during REQ: no retraction. interrupcion and vector hold until ack, even if the source becomes masked.
- A higher-priority request arriving during REQ does not preempt. It is served after GAP.
- Config write with cfg_addr=0: mask ← cfg_data[3:0], effective the next cycle.
- Reset mid-handshake: state returns to IDLE and interrupcion drops asynchronously. Pending requests are lost.

## Timing
- Reset values: interrupcion=0, vector=0, pending=0, mask=0, timer period=0, prescaler=0, timer counter=0, state=IDLE, synchronisers=0.
- ev[i] rising, sampled at edge n → pending[i]=1 after edge n+SYNC_STAGES+1.
- pending set with mask enabled → interrupcion=1 after the next edge. With SYNC_STAGES=2, total latency is 4 edges.
- ack sampled at edge m → interrupcion=0 and pending bit clear after edge m. The earliest re-assertion is after edge m+2.
- Event pulses shorter than one clk period may be missed and are not guaranteed to register.

## Configuration
- Macro: CTRL_INTERRUPCIONES_TIMER_EN.
- Defined:
  - Source 3 is an internal timer and ev[3] is ignored.
  - Config write with cfg_addr=1 loads period ← cfg_data, loads counter ← cfg_data, and clears the prescaler.
  - The prescaler counts 0..PRESCALE-1. On wrap the counter decrements.
  - When the counter goes 1→0: set pending[3] and reload counter ← period. One interrupt fires every period×PRESCALE cycles.
  - period=0 stops the timer and produces no interrupts.
- Undefined:
  - Source 3 is ev[3], identical to sources 0–2.
  - cfg_addr=1 writes are ignored.
  - No timer logic is synthesised.

## Test plan
- Reset test: assert reset mid-REQ → interrupcion=0, vector=0, pending=0 within the same cycle. Outputs stay 0 until after deassert plus an event.
- Single event: mask=4'b0010, rising edge on ev[1] at edge 0 → pending=4'b0010 after edge 3, interrupcion=1 and vector=1 after edge 4. ack at edge 8 → interrupcion=0, pending=0.
- Priority: mask=4'b1111, ev[2] and ev[0] rise together → vector=0 first. After ack plus GAP → vector=2.
- Masking: mask=0, ev[3] rises → pending=4'b1000, interrupcion stays 0. Write mask=4'b1000 → interrupcion=1, vector=3 two cycles after the write.
- Set-wins race: in REQ with vector=1, ev[1] edge detected in the ack cycle → pending[1] remains 1 and interrupcion reasserts after GAP.
- Timer (CTRL_INTERRUPCIONES_TIMER_EN defined, PRESCALE=16):
  - Write mask=4'b1000, then period=3 → pending[3] sets 48 cycles after the write and again every 48 cycles.
  - Write period=0 → no further sets.

Source files
------------

// File: rtl/ctrl_interrupciones.sv
// Four-source interrupt controller with edge-detected, maskable, fixed-priority requests and a CPU handshake.
// Define CTRL_INTERRUPCIONES_TIMER_EN to replace source 3 with an internal periodic timer.
module ctrl_interrupciones #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ev,
  input  logic       cfg_we,
  input  logic       cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       ack,
  output logic       interrupcion,
  output logic [1:0] vector,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t     state_q, state_d;
  logic       int_d;
  logic [1:0] vec_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] edge_q, hist_q, rise, set_req, ack_clr, mask_q, req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      edge_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= ev;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      edge_q <= sync_q[SYNC_STAGES-1];
      hist_q <= edge_q;
    end
  end

  assign rise = edge_q & ~hist_q;

`ifdef CTRL_INTERRUPCIONES_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]    period_q, count_q;
  logic [PW-1:0] presc_q;
  logic          period_wr, wrap, timer_fire, ev3_unused;

  assign period_wr  = cfg_we && cfg_addr;
  assign wrap       = (presc_q == PW'(PRESCALE - 1));
  assign timer_fire = wrap && (count_q == 8'd1) && !period_wr;
  assign ev3_unused = rise[3];

  // A period write restarts the countdown from a clean prescaler phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
    end else if (period_wr) begin
      period_q <= cfg_data;
      count_q  <= cfg_data;
      presc_q  <= '0;
    end else if (wrap) begin
      presc_q <= '0;
      if (count_q == 8'd1)      count_q <= period_q;
      else if (count_q != 8'd0) count_q <= count_q - 8'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign set_req = {timer_fire, rise[2:0]};
`else
  logic cfg_unused;

  assign cfg_unused = ^cfg_data[7:4];
  assign set_req    = rise;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else if (cfg_we && !cfg_addr) mask_q <= cfg_data[3:0];
  end

  // A new edge in the acknowledge cycle must survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~ack_clr) | set_req;
  end

  assign req = pending & mask_q;

  function automatic logic [1:0] highest_prio(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      interrupcion <= 1'b0;
      vector       <= 2'd0;
    end else begin
      state_q      <= state_d;
      interrupcion <= int_d;
      vector       <= vec_d;
    end
  end

  // Vector is frozen for the whole request; masking or new arrivals never retract it.
  always_comb begin
    state_d = state_q;
    int_d   = interrupcion;
    vec_d   = vector;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          int_d   = 1'b1;
          vec_d   = highest_prio(req);
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          int_d   = 1'b0;
          ack_clr = 4'b0001 << vector;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_interrupciones.sv
// Bench for ctrl_interrupciones: directed latency/race/reset checks, then randomized traffic scored against a priority-queue model.
module tb_ctrl_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ev;
  logic       cfg_we;
  logic       cfg_addr;
  logic [7:0] cfg_data;
  logic       ack;
  logic       interrupcion;
  logic [1:0] vector;
  logic [3:0] pending;

  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  bit   mon_en = 1'b0;
  bit   busy   = 1'b0;
  logic [3:0] pending_m, mask_m;

  ctrl_interrupciones #(.SYNC_STAGES(2), .PRESCALE(16)) dut (
    .clk(clk), .reset(reset), .ev(ev), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ack(ack), .interrupcion(interrupcion),
    .vector(vector), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic addr, input logic [7:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    wait_edge();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    wait_edge();
    ack = 1'b0;
  endtask

  // Every masked pending source is served once, lowest index first, when they are all present together.
  task automatic push_serves();
    logic [3:0] r;
    r = pending_m & mask_m;
    for (int i = 0; i < 4; i++) if (r[i]) exp_q.push_back(i);
    pending_m = pending_m & ~r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      wait_edge();
      n++;
    end
    check_output("drain_outstanding", exp_q.size() + int'(busy), 0);
  endtask

  task automatic apply_stimulus(input logic [3:0] s);
    @(negedge clk);
    ev = s;
    pending_m = pending_m | s;
    push_serves();
    repeat (6) wait_edge();
    ev = 4'b0;
  endtask

  // Monitor: acknowledges each new request and scores it against the queue head.
  initial begin
    logic prev;
    int   v;
    prev = 1'b0;
    forever begin
      wait_edge();
      if (mon_en && interrupcion && !prev) begin
        busy = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_req: got vector %0d, expected no request", vector);
          v = int'(vector);
        end else begin
          v = exp_q.pop_front();
          check_output("serve_vector", vector, v);
          check_output("serve_pending_bit", pending[v], 1);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        pulse_ack();
        check_output("ack_drops_req", interrupcion, 0);
        check_output("ack_clears_bit", pending[v], 0);
        busy = 1'b0;
      end
      prev = interrupcion;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] s;
    reset = 1'b1; ev = 4'b0; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_data = 8'h00; ack = 1'b0;
    repeat (3) wait_edge();
    check_output("reset_int", interrupcion, 0);
    check_output("reset_vector", vector, 0);
    check_output("reset_pending", pending, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single event latency: edge 0 sample, pending after edge 3, request after edge 4.
    write_cfg(1'b0, 8'h02);
    @(negedge clk);
    ev[1] = 1'b1;
    repeat (3) wait_edge();
    check_output("pend_before_edge3", pending, 0);
    wait_edge();
    check_output("pend_after_edge3", pending, 4'b0010);
    check_output("int_before_edge4", interrupcion, 0);
    wait_edge();
    check_output("int_after_edge4", interrupcion, 1);
    check_output("vec_after_edge4", vector, 1);
    repeat (3) wait_edge();
    pulse_ack();
    ev[1] = 1'b0;
    check_output("single_ack_int", interrupcion, 0);
    check_output("single_ack_pend", pending, 0);

    // Set-wins race: re-edge on the served line lands in the ack cycle.
    repeat (4) wait_edge();
    @(negedge clk);
    ev[1] = 1'b1;
    repeat (5) wait_edge();
    ev[1] = 1'b0;
    check_output("race_req_up", interrupcion, 1);
    repeat (4) wait_edge();
    @(negedge clk);
    ev[1] = 1'b1;
    repeat (3) wait_edge();
    pulse_ack();
    check_output("race_ack_int", interrupcion, 0);
    check_output("race_set_wins", pending[1], 1);
    wait_edge();
    check_output("race_gap_int", interrupcion, 0);
    wait_edge();
    check_output("race_reassert", interrupcion, 1);
    check_output("race_vector", vector, 1);
    pulse_ack();
    ev[1] = 1'b0;
    check_output("race_final_pend", pending, 0);

`ifndef CTRL_INTERRUPCIONES_TIMER_EN
    // Masked source stays pending, then fires after the mask opens.
    write_cfg(1'b0, 8'h00);
    @(negedge clk);
    ev[3] = 1'b1;
    repeat (5) wait_edge();
    ev[3] = 1'b0;
    check_output("masked_pend", pending, 4'b1000);
    check_output("masked_int", interrupcion, 0);
    write_cfg(1'b0, 8'h08);
    check_output("unmask_same_edge", interrupcion, 0);
    wait_edge();
    check_output("unmask_int", interrupcion, 1);
    check_output("unmask_vector", vector, 3);
    pulse_ack();
`else
    // Timer: period 3 with prescale 16 sets pending[3] every 48 cycles.
    write_cfg(1'b0, 8'h08);
    write_cfg(1'b1, 8'h03);
    repeat (47) wait_edge();
    check_output("timer_before_48", pending[3], 0);
    wait_edge();
    check_output("timer_at_48", pending[3], 1);
    wait_edge();
    check_output("timer_int", interrupcion, 1);
    check_output("timer_vector", vector, 3);
    pulse_ack();
    repeat (45) wait_edge();
    check_output("timer_before_96", pending[3], 0);
    wait_edge();
    check_output("timer_at_96", pending[3], 1);
    wait_edge();
    pulse_ack();
    write_cfg(1'b1, 8'h00);
    repeat (120) wait_edge();
    check_output("timer_stopped_pend", pending, 0);
    check_output("timer_stopped_int", interrupcion, 0);
`endif

    // Reset in the middle of a request clears everything immediately.
    write_cfg(1'b0, 8'h01);
    @(negedge clk);
    ev[0] = 1'b1;
    repeat (5) wait_edge();
    ev[0] = 1'b0;
    check_output("prereset_int", interrupcion, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("midreq_reset_int", interrupcion, 0);
    check_output("midreq_reset_vector", vector, 0);
    check_output("midreq_reset_pend", pending, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) wait_edge();
    check_output("postreset_int", interrupcion, 0);
    check_output("postreset_pend", pending, 0);

    // Randomized traffic against the model.
    pending_m = 4'b0;
    mask_m    = 4'b0;
    mon_en    = 1'b1;
    for (int iter = 0; iter < 25; iter++) begin
      mask_m = 4'($urandom_range(0, 15));
      write_cfg(1'b0, {4'b0, mask_m});
      push_serves();
      drain();
      s = 4'($urandom_range(1, 15));
`ifdef CTRL_INTERRUPCIONES_TIMER_EN
      s[3] = 1'b0;
`endif
      apply_stimulus(s);
      drain();
      repeat (4) wait_edge();
      check_output("rand_pending", pending, pending_m);
    end
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
